// File: rtl/ex_mem_hilo.sv
// ex_mem_hilo: EX/MEM pipeline register plus the HI/LO special registers.
//
// The pipeline half captures the execute-stage result, store data,
// destination, link address and control bits, with Stall (hold) and
// Flush (bubble). The HI/LO half commits mult/div results a fixed number
// of cycles after acceptance, serves mfhi/mflo, and applies mthi/mtlo.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   ALUResult, ALULR, mb, mrd, E_A   execute-stage data
//   E_PC8                            PC+8 link value
//   E_RegWrite..E_PcToReg            control bits copied to MEM
//   E_HiLoWrite, E_IsDiv             mult/div result write and latency select
//   E_MtHi, E_MtLo, E_MfHi, E_MfLo   special-register moves
//   Stall, Flush                     pipeline hold / bubble insert
//   M_*                              latched MEM-stage values
//   M_Fwd                            forwarding value (link or ALU result)
//   HI, LO                           architectural special registers
//   Busy                             HI/LO commit pending
//
// HI/LO commit FSM
//   state | meaning
//   IDLE  | no commit outstanding, cnt == 0
//   PEND  | mult/div result held in pending, cnt cycles until it lands

module ex_mem_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResult,
    input  logic [63:0] ALULR,
    input  logic [31:0] mb,
    input  logic [4:0]  mrd,
    input  logic [31:0] E_A,
    input  logic [31:0] E_PC8,
    input  logic        E_RegWrite,
    input  logic        E_MemWrite,
    input  logic        E_MemToReg,
    input  logic        E_PcToReg,
    input  logic        E_HiLoWrite,
    input  logic        E_IsDiv,
    input  logic        E_MtHi,
    input  logic        E_MtLo,
    input  logic        E_MfHi,
    input  logic        E_MfLo,
    input  logic        Stall,
    input  logic        Flush,
    output logic [31:0] M_ALUResult,
    output logic [31:0] M_B,
    output logic [31:0] M_PC8,
    output logic [4:0]  M_RD,
    output logic        M_RegWrite,
    output logic        M_MemWrite,
    output logic        M_MemToReg,
    output logic        M_PcToReg,
    output logic [31:0] M_Fwd,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {IDLE, PEND} hilo_state_t;

    hilo_state_t   state;
    logic [CW-1:0] cnt;
    logic [63:0]   pending;
    logic          adv;

    assign adv   = !Stall && !Flush;
    assign Busy  = (cnt != '0);
    assign M_Fwd = M_PcToReg ? M_PC8 : M_ALUResult;

    always_ff @(posedge clk) begin
        if (reset) begin
            M_ALUResult <= '0;
            M_B         <= '0;
            M_PC8       <= '0;
            M_RD        <= '0;
            M_RegWrite  <= 1'b0;
            M_MemWrite  <= 1'b0;
            M_MemToReg  <= 1'b0;
            M_PcToReg   <= 1'b0;
            HI          <= '0;
            LO          <= '0;
            pending     <= '0;
            cnt         <= '0;
            state       <= IDLE;
        end else begin
            if (!Stall) begin
                if (Flush) begin
                    M_ALUResult <= '0;
                    M_B         <= '0;
                    M_PC8       <= '0;
                    M_RD        <= '0;
                    M_RegWrite  <= 1'b0;
                    M_MemWrite  <= 1'b0;
                    M_MemToReg  <= 1'b0;
                    M_PcToReg   <= 1'b0;
                end else begin
                    // mfhi/mflo read the pre-edge HI/LO; stale while Busy.
                    M_ALUResult <= E_MfHi ? HI : (E_MfLo ? LO : ALUResult);
                    M_B         <= mb;
                    M_PC8       <= E_PC8;
                    M_RD        <= mrd;
                    M_RegWrite  <= E_RegWrite;
                    M_MemWrite  <= E_MemWrite;
                    M_MemToReg  <= E_MemToReg;
                    M_PcToReg   <= E_PcToReg;
                end
            end

            // A new mult/div beats a simultaneous mthi/mtlo and restarts
            // any commit already in flight.
            if (adv && E_HiLoWrite) begin
                pending <= ALULR;
                cnt     <= E_IsDiv ? DIV_CNT : MULT_CNT;
                state   <= PEND;
            end else if (adv && (E_MtHi || E_MtLo)) begin
                if (E_MtHi) HI <= E_A;
                if (E_MtLo) LO <= E_A;
                cnt   <= '0;
                state <= IDLE;
            end else if (state == PEND) begin
                if (cnt == CNT_ONE) begin
                    {HI, LO} <= pending;
                    cnt      <= '0;
                    state    <= IDLE;
                end else begin
                    cnt <= cnt - CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_hilo.sv
module tb_ex_mem_hilo;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUResult, mb, E_A, E_PC8;
    logic [63:0] ALULR;
    logic [4:0]  mrd;
    logic        E_RegWrite, E_MemWrite, E_MemToReg, E_PcToReg;
    logic        E_HiLoWrite, E_IsDiv, E_MtHi, E_MtLo, E_MfHi, E_MfLo;
    logic        Stall, Flush;
    logic [31:0] M_ALUResult, M_B, M_PC8, M_Fwd, HI, LO;
    logic [4:0]  M_RD;
    logic        M_RegWrite, M_MemWrite, M_MemToReg, M_PcToReg, Busy;

    int checks = 0;
    int failures = 0;

    ex_mem_hilo #(.MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .ALUResult(ALUResult), .ALULR(ALULR),
        .mb(mb), .mrd(mrd), .E_A(E_A), .E_PC8(E_PC8),
        .E_RegWrite(E_RegWrite), .E_MemWrite(E_MemWrite),
        .E_MemToReg(E_MemToReg), .E_PcToReg(E_PcToReg),
        .E_HiLoWrite(E_HiLoWrite), .E_IsDiv(E_IsDiv),
        .E_MtHi(E_MtHi), .E_MtLo(E_MtLo), .E_MfHi(E_MfHi), .E_MfLo(E_MfLo),
        .Stall(Stall), .Flush(Flush),
        .M_ALUResult(M_ALUResult), .M_B(M_B), .M_PC8(M_PC8), .M_RD(M_RD),
        .M_RegWrite(M_RegWrite), .M_MemWrite(M_MemWrite),
        .M_MemToReg(M_MemToReg), .M_PcToReg(M_PcToReg),
        .M_Fwd(M_Fwd), .HI(HI), .LO(LO), .Busy(Busy)
    );

    always #5 clk = ~clk;

    // Reference model: the commit is tracked as an absolute edge number
    // ("due") at which pending lands in HI/LO; -1 means nothing outstanding.
    logic [31:0] x_alu, x_b, x_pc8, x_hi, x_lo;
    logic [63:0] x_pend;
    logic [4:0]  x_rd;
    logic        x_rw, x_mw, x_mtr, x_ptr;
    int          edge_n = 0;
    int          due = -1;

    task automatic idle();
        reset = 0; Stall = 0; Flush = 0;
        ALUResult = 0; ALULR = 0; mb = 0; mrd = 0; E_A = 0; E_PC8 = 0;
        E_RegWrite = 0; E_MemWrite = 0; E_MemToReg = 0; E_PcToReg = 0;
        E_HiLoWrite = 0; E_IsDiv = 0; E_MtHi = 0; E_MtLo = 0; E_MfHi = 0; E_MfLo = 0;
    endtask

    task automatic rand_inputs();
        ALUResult = $urandom; ALULR = {$urandom, $urandom}; mb = $urandom;
        mrd = 5'($urandom); E_A = $urandom; E_PC8 = $urandom;
        E_RegWrite = 1'($urandom); E_MemWrite = 1'($urandom);
        E_MemToReg = 1'($urandom); E_PcToReg = 1'($urandom);
        E_HiLoWrite = ($urandom_range(0, 7) == 0); E_IsDiv = 1'($urandom);
        E_MtHi = ($urandom_range(0, 9) == 0); E_MtLo = ($urandom_range(0, 9) == 0);
        E_MfHi = ($urandom_range(0, 5) == 0); E_MfLo = ($urandom_range(0, 5) == 0);
        Stall = ($urandom_range(0, 5) == 0); Flush = ($urandom_range(0, 6) == 0);
    endtask

    // Advance the model by one edge from the currently driven inputs, then
    // clock the DUT and settle 1 time unit past the edge.
    task automatic step();
        int  this_edge;
        logic a;
        this_edge = edge_n + 1;
        if (reset) begin
            {x_alu, x_b, x_pc8, x_rd, x_rw, x_mw, x_mtr, x_ptr} = '0;
            x_hi = 0; x_lo = 0; x_pend = 0; due = -1;
        end else begin
            a = !Stall && !Flush;
            if (!Stall) begin
                if (Flush) begin
                    {x_alu, x_b, x_pc8, x_rd, x_rw, x_mw, x_mtr, x_ptr} = '0;
                end else begin
                    x_alu = E_MfHi ? x_hi : (E_MfLo ? x_lo : ALUResult);
                    x_b = mb; x_pc8 = E_PC8; x_rd = mrd;
                    x_rw = E_RegWrite; x_mw = E_MemWrite;
                    x_mtr = E_MemToReg; x_ptr = E_PcToReg;
                end
            end
            if (a && E_HiLoWrite) begin
                x_pend = ALULR;
                due = this_edge + (E_IsDiv ? DIV_LAT : MULT_LAT);
            end else if (a && (E_MtHi || E_MtLo)) begin
                if (E_MtHi) x_hi = E_A;
                if (E_MtLo) x_lo = E_A;
                due = -1;
            end else if (due == this_edge) begin
                {x_hi, x_lo} = x_pend;
                due = -1;
            end
        end
        @(posedge clk);
        edge_n = this_edge;
        #1;
    endtask

    task automatic test_reset();
        rand_inputs();
        reset = 1;
        step();
        rand_inputs();
        reset = 1;
        step();
        checks++;
        if ({M_ALUResult, M_B, M_PC8, M_RD, M_RegWrite, M_MemWrite, M_MemToReg, M_PcToReg,
             M_Fwd, HI, LO, Busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h/%h/%h rd=%h ctl=%b%b%b%b fwd=%h hi=%h lo=%h busy=%b required all zero",
                     M_ALUResult, M_B, M_PC8, M_RD, M_RegWrite, M_MemWrite, M_MemToReg, M_PcToReg,
                     M_Fwd, HI, LO, Busy);
        end
        idle();
        ALUResult = 32'h12; mrd = 5'd8; E_RegWrite = 1;
        step();
        checks++;
        if (M_ALUResult !== 32'h12 || M_RD !== 5'd8 || M_RegWrite !== 1'b1) begin
            failures++;
            $display("FAIL first_add: got alu=%h rd=%0d rw=%b required alu=12 rd=8 rw=1",
                     M_ALUResult, M_RD, M_RegWrite);
        end
    endtask

    task automatic test_mult_div();
        int n;
        idle();
        ALULR = 64'h00000001_FFFFFFFE; E_HiLoWrite = 1;
        step();
        idle();
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            n++;
            step();
        end
        checks++;
        if (n != MULT_LAT) begin
            failures++;
            $display("FAIL mult_busy_cycles: got %0d required %0d", n, MULT_LAT);
        end
        checks++;
        if (HI !== 32'h00000001 || LO !== 32'hFFFFFFFE) begin
            failures++;
            $display("FAIL mult_commit: got hi=%h lo=%h required hi=00000001 lo=fffffffe", HI, LO);
        end
        ALULR = 64'h00000003_00000007; E_HiLoWrite = 1; E_IsDiv = 1;
        step();
        idle();
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            checks++;
            if (HI !== 32'h00000001 || LO !== 32'hFFFFFFFE) begin
                failures++;
                $display("FAIL div_early_commit: got hi=%h lo=%h during busy cycle %0d", HI, LO, n);
            end
            n++;
            step();
        end
        checks++;
        if (n != DIV_LAT) begin
            failures++;
            $display("FAIL div_busy_cycles: got %0d required %0d", n, DIV_LAT);
        end
        checks++;
        if (HI !== 32'h00000003 || LO !== 32'h00000007) begin
            failures++;
            $display("FAIL div_commit: got hi=%h lo=%h required hi=00000003 lo=00000007", HI, LO);
        end
    endtask

    task automatic test_stall_flush();
        idle();
        ALUResult = 32'hA5; mrd = 5'd3; E_RegWrite = 1; mb = 32'h77;
        step();
        idle();
        Stall = 1; ALUResult = 32'hBEEF; mrd = 5'd9; E_RegWrite = 1; E_HiLoWrite = 1;
        step();
        checks++;
        if (M_ALUResult !== 32'hA5 || M_RD !== 5'd3 || M_RegWrite !== 1'b1 || M_B !== 32'h77) begin
            failures++;
            $display("FAIL stall_hold: got alu=%h rd=%0d rw=%b b=%h required alu=a5 rd=3 rw=1 b=77",
                     M_ALUResult, M_RD, M_RegWrite, M_B);
        end
        checks++;
        if (Busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_no_accept: got busy=%b required 0", Busy);
        end
        Flush = 1;
        step();
        checks++;
        if (M_ALUResult !== 32'hA5 || M_RD !== 5'd3 || M_RegWrite !== 1'b1 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_flush_hold: got alu=%h rd=%0d rw=%b busy=%b required alu=a5 rd=3 rw=1 busy=0",
                     M_ALUResult, M_RD, M_RegWrite, Busy);
        end
        Stall = 0;
        step();
        checks++;
        if (M_RegWrite !== 1'b0 || M_RD !== 5'd0 || M_ALUResult !== 32'h0 || M_B !== 32'h0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_bubble: got rw=%b rd=%0d alu=%h b=%h busy=%b required all 0",
                     M_RegWrite, M_RD, M_ALUResult, M_B, Busy);
        end
    endtask

    task automatic test_mfhi_link();
        idle();
        E_MtHi = 1; E_A = 32'hCAFEBABE;
        step();
        checks++;
        if (HI !== 32'hCAFEBABE) begin
            failures++;
            $display("FAIL mthi_write: got %h required cafebabe", HI);
        end
        idle();
        E_MfHi = 1; ALUResult = 32'h1;
        step();
        checks++;
        if (M_ALUResult !== 32'hCAFEBABE) begin
            failures++;
            $display("FAIL mfhi_read: got %h required cafebabe", M_ALUResult);
        end
        idle();
        E_PcToReg = 1; E_PC8 = 32'h3008; ALUResult = $urandom;
        step();
        checks++;
        if (M_Fwd !== 32'h3008) begin
            failures++;
            $display("FAIL link_fwd: got %h required 00003008", M_Fwd);
        end
    endtask

    task automatic test_mthi_pend();
        idle();
        E_MtLo = 1; E_A = 32'h1234;
        step();
        idle();
        ALULR = {$urandom, $urandom}; E_HiLoWrite = 1;
        step();
        idle();
        step();
        E_MtHi = 1; E_A = 32'h55;
        step();
        checks++;
        if (HI !== 32'h55 || LO !== 32'h1234 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL mthi_cancel: got hi=%h lo=%h busy=%b required hi=55 lo=1234 busy=0", HI, LO, Busy);
        end
        idle();
        repeat (MULT_LAT + 2) step();
        checks++;
        if (HI !== 32'h55 || LO !== 32'h1234 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL mthi_no_late_commit: got hi=%h lo=%h busy=%b required hi=55 lo=1234 busy=0", HI, LO, Busy);
        end
    endtask

    task automatic test_reset_pend();
        idle();
        ALULR = 64'hDEADBEEF_12345678; E_HiLoWrite = 1; E_IsDiv = 1;
        step();
        idle();
        step();
        step();
        reset = 1;
        step();
        reset = 0;
        checks++;
        if (HI !== 32'h0 || LO !== 32'h0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_pend: got hi=%h lo=%h busy=%b required 0/0/0", HI, LO, Busy);
        end
        repeat (DIV_LAT + 2) step();
        checks++;
        if (HI !== 32'h0 || LO !== 32'h0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_commit: got hi=%h lo=%h busy=%b required 0/0/0", HI, LO, Busy);
        end
    endtask

    task automatic test_random();
        logic [31:0] x_fwd;
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            reset = ($urandom_range(0, 99) == 0);
            step();
            x_fwd = x_ptr ? x_pc8 : x_alu;
            checks++;
            if ({M_ALUResult, M_B, M_PC8, M_RD, M_RegWrite, M_MemWrite, M_MemToReg, M_PcToReg, M_Fwd}
                !== {x_alu, x_b, x_pc8, x_rd, x_rw, x_mw, x_mtr, x_ptr, x_fwd}) begin
                failures++;
                $display("FAIL rand_pipe[%0d]: got %h %h %h %h %b%b%b%b %h required %h %h %h %h %b%b%b%b %h", i,
                         M_ALUResult, M_B, M_PC8, M_RD, M_RegWrite, M_MemWrite, M_MemToReg, M_PcToReg, M_Fwd,
                         x_alu, x_b, x_pc8, x_rd, x_rw, x_mw, x_mtr, x_ptr, x_fwd);
            end
            checks++;
            if (HI !== x_hi || LO !== x_lo || Busy !== (due != -1)) begin
                failures++;
                $display("FAIL rand_hilo[%0d]: got hi=%h lo=%h busy=%b required hi=%h lo=%h busy=%b", i,
                         HI, LO, Busy, x_hi, x_lo, (due != -1));
            end
        end
    endtask

    initial begin
        idle();
        #2;
        test_reset();
        test_mult_div();
        test_stall_flush();
        test_mfhi_link();
        test_mthi_pend();
        test_reset_pend();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
